// File: rtl/cv_tile_scheduler_pkg.sv
// Shared definitions for the convolution tile scheduler: FSM state encoding
// and the field widths used by the loader-facing origin/extent outputs.
package cv_tile_scheduler_pkg;

    localparam int CH_W = 11;  // output-channel fields and all internal axis math
    localparam int SP_W = 8;   // spatial origin/extent fields
    localparam int K_W  = 5;   // kernel size

    localparam logic [CH_W-1:0] CH_ZERO  = '0;
    localparam logic [CH_W-1:0] CH_ONE   = CH_W'(1);
    localparam logic [CH_W-1:0] SPAN_MAX = CH_W'(255);  // largest allowed H-K / W-K

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WGT  = 3'd1,
        ST_INP  = 3'd2,
        ST_OUT  = 3'd3,
        ST_NEXT = 3'd4,
        ST_FIN  = 3'd5
    } state_t;

endpackage

// File: rtl/cv_tile_axis_step.sv
// One tiling axis. Optionally advances the origin by one tile step (wrapping
// to 0 at the end of the axis) and returns the extent of the tile at the
// resulting origin: min(step, total - origin) plus the kernel halo.
module cv_tile_axis_step
    import cv_tile_scheduler_pkg::*;
(
    input  logic            advance,
    input  logic [CH_W-1:0] origin,
    input  logic [CH_W-1:0] step,
    input  logic [CH_W-1:0] total,
    input  logic [CH_W-1:0] halo,
    output logic [CH_W-1:0] new_origin,
    output logic [CH_W-1:0] extent,
    output logic            wrap
);

    logic [CH_W:0]   sum;
    logic [CH_W-1:0] remain;
    logic [CH_W-1:0] span;

    // Step/wrap the origin, then size the tile that starts at the new origin.
    always_comb begin
        sum  = {1'b0, origin} + {1'b0, step};
        wrap = advance && (sum >= {1'b0, total});
        if (!advance) begin
            new_origin = origin;
        end else if (wrap) begin
            new_origin = '0;
        end else begin
            new_origin = sum[CH_W-1:0];
        end
        remain = total - new_origin;
        span   = (step < remain) ? step : remain;
        extent = span + halo;
    end

endmodule

// File: rtl/cv_tile_scheduler.sv
// Walks a stride-1 valid convolution in output tiles (o outer, h middle,
// w inner) and sequences load_weight / load_input / store_output for the
// loader. Weights are reloaded only when the output-channel tile changes.
// Handshake: each command is a level held for its whole state; the loader
// pulses ld_done once, and the command drops in the following cycle.
module cv_tile_scheduler
    import cv_tile_scheduler_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [CH_W-1:0] O,
    input  logic [K_W-1:0]  K,
    input  logic [CH_W-1:0] H,
    input  logic [CH_W-1:0] W,
    input  logic [CH_W-1:0] tile_o,
    input  logic [SP_W-1:0] tile_h,
    input  logic [SP_W-1:0] tile_w,
    input  logic            ld_done,
    output logic            load_weight,
    output logic            load_input,
    output logic            store_output,
    output logic [CH_W-1:0] Oori,
    output logic [SP_W-1:0] Hori,
    output logic [SP_W-1:0] Wori,
    output logic [CH_W-1:0] Oext,
    output logic [SP_W-1:0] Hext,
    output logic [SP_W-1:0] Wext,
    output logic            busy,
    output logic            finished,
    output logic            cfg_err
);

    state_t state_q, state_d;

    // Latched layer configuration, already reduced to per-axis terms.
    logic [CH_W-1:0] o_tot_q, tile_o_q, hout_q, wout_q, toh_q, tow_q, halo_q;

    logic [CH_W-1:0] k_in, th_in, tw_in, hout_in, wout_in, toh_in, tow_in, halo_in;
    logic            cfg_bad, in_idle, accept, step_en;

    logic [CH_W-1:0] o_total, o_step, h_total, h_step, w_total, w_step, halo;
    logic [CH_W-1:0] o_org, h_org, w_org;
    logic [CH_W-1:0] o_new, h_new, w_new, o_ext, h_ext, w_ext;
    logic            o_wrap, h_wrap, w_wrap;
    logic            unused_hi;

    // Derive per-axis terms from the raw ports and validate the configuration.
    always_comb begin
        k_in    = CH_W'(K);
        th_in   = CH_W'(tile_h);
        tw_in   = CH_W'(tile_w);
        hout_in = H - k_in + CH_ONE;
        wout_in = W - k_in + CH_ONE;
        toh_in  = th_in - k_in + CH_ONE;
        tow_in  = tw_in - k_in + CH_ONE;
        halo_in = k_in - CH_ONE;
        cfg_bad = (K == '0) || (O == '0) || (tile_o == '0) ||
                  (th_in < k_in) || (tw_in < k_in) || (H < k_in) || (W < k_in) ||
                  ((H - k_in) > SPAN_MAX) || ((W - k_in) > SPAN_MAX);
    end

    // In IDLE the axis steppers size the first tile straight from the ports,
    // so the fields are valid in the same cycle WGT is entered.
    always_comb begin
        in_idle = (state_q == ST_IDLE);
        accept  = in_idle && start && !cfg_bad;
        step_en = (state_q == ST_NEXT);
        o_total = in_idle ? O       : o_tot_q;
        o_step  = in_idle ? tile_o  : tile_o_q;
        h_total = in_idle ? hout_in : hout_q;
        h_step  = in_idle ? toh_in  : toh_q;
        w_total = in_idle ? wout_in : wout_q;
        w_step  = in_idle ? tow_in  : tow_q;
        halo    = in_idle ? halo_in : halo_q;
        o_org   = in_idle ? CH_ZERO : Oori;
        h_org   = in_idle ? CH_ZERO : CH_W'(Hori);
        w_org   = in_idle ? CH_ZERO : CH_W'(Wori);
    end

    cv_tile_axis_step u_w_axis (
        .advance(step_en), .origin(w_org), .step(w_step), .total(w_total),
        .halo(halo), .new_origin(w_new), .extent(w_ext), .wrap(w_wrap)
    );

    cv_tile_axis_step u_h_axis (
        .advance(w_wrap), .origin(h_org), .step(h_step), .total(h_total),
        .halo(halo), .new_origin(h_new), .extent(h_ext), .wrap(h_wrap)
    );

    cv_tile_axis_step u_o_axis (
        .advance(h_wrap), .origin(o_org), .step(o_step), .total(o_total),
        .halo(CH_ZERO), .new_origin(o_new), .extent(o_ext), .wrap(o_wrap)
    );

    // Spatial values never exceed 8 bits once the configuration is accepted.
    assign unused_hi = ^{h_new[CH_W-1:SP_W], w_new[CH_W-1:SP_W],
                         h_ext[CH_W-1:SP_W], w_ext[CH_W-1:SP_W]};

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic; an o-axis wrap in NEXT means the layer is complete.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept)  state_d = ST_WGT;
            ST_WGT:  if (ld_done) state_d = ST_INP;
            ST_INP:  if (ld_done) state_d = ST_OUT;
            ST_OUT:  if (ld_done) state_d = ST_NEXT;
            ST_NEXT: begin
                if (o_wrap)      state_d = ST_FIN;
                else if (h_wrap) state_d = ST_WGT;
                else             state_d = ST_INP;
            end
            ST_FIN:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Commands and status decode directly from the state register.
    always_comb begin
        load_weight  = (state_q == ST_WGT);
        load_input   = (state_q == ST_INP);
        store_output = (state_q == ST_OUT);
        busy         = (state_q == ST_WGT) || (state_q == ST_INP) ||
                       (state_q == ST_OUT) || (state_q == ST_NEXT);
        finished     = (state_q == ST_FIN);
    end

    // Latch configuration on accept; load tile fields on accept and in NEXT.
    always_ff @(posedge clk) begin
        if (rst) begin
            cfg_err  <= 1'b0;
            o_tot_q  <= '0;
            tile_o_q <= '0;
            hout_q   <= '0;
            wout_q   <= '0;
            toh_q    <= '0;
            tow_q    <= '0;
            halo_q   <= '0;
            Oori     <= '0;
            Hori     <= '0;
            Wori     <= '0;
            Oext     <= '0;
            Hext     <= '0;
            Wext     <= '0;
        end else begin
            cfg_err <= in_idle && start && cfg_bad;
            if (accept) begin
                o_tot_q  <= O;
                tile_o_q <= tile_o;
                hout_q   <= hout_in;
                wout_q   <= wout_in;
                toh_q    <= toh_in;
                tow_q    <= tow_in;
                halo_q   <= halo_in;
            end
            if (accept || (step_en && !o_wrap)) begin
                Oori <= o_new;
                Hori <= h_new[SP_W-1:0];
                Wori <= w_new[SP_W-1:0];
                Oext <= o_ext;
                Hext <= h_ext[SP_W-1:0];
                Wext <= w_ext[SP_W-1:0];
            end
        end
    end

endmodule

// File: tb/tb_cv_tile_scheduler.sv
// Bench for cv_tile_scheduler: a table of layer configurations with known
// tile/weight counts, random layers, and hand sequences for long ld_done
// delays, start-while-busy and mid-layer reset. The expected command/field
// stream comes from plain nested loops over the tiling rules.
module tb_cv_tile_scheduler;

    localparam logic [1:0] CMD_W = 2'd0;
    localparam logic [1:0] CMD_I = 2'd1;
    localparam logic [1:0] CMD_S = 2'd2;

    typedef struct {
        int o, k, h, w, to, th, tw;
        int exp_tiles;   // -1 = not checked
        int exp_wgts;
        bit exp_err;
    } cfg_t;

    logic        clk = 1'b0;
    logic        rst, start, ld_done;
    logic [10:0] O, H, W, tile_o;
    logic [4:0]  K;
    logic [7:0]  tile_h, tile_w;
    logic        load_weight, load_input, store_output, busy, finished, cfg_err;
    logic [10:0] Oori, Oext;
    logic [7:0]  Hori, Wori, Hext, Wext;

    int errors = 0;
    int checks = 0;
    logic [55:0] exp_q[$];  // {cmd[1:0], Oori, Hori, Wori, Oext, Hext, Wext}
    cfg_t tbl[13];

    cv_tile_scheduler dut (
        .clk(clk), .rst(rst), .start(start), .O(O), .K(K), .H(H), .W(W),
        .tile_o(tile_o), .tile_h(tile_h), .tile_w(tile_w), .ld_done(ld_done),
        .load_weight(load_weight), .load_input(load_input), .store_output(store_output),
        .Oori(Oori), .Hori(Hori), .Wori(Wori), .Oext(Oext), .Hext(Hext), .Wext(Wext),
        .busy(busy), .finished(finished), .cfg_err(cfg_err)
    );

    // Clock.
    always #5 clk = ~clk;

    // Hard time limit so the run always ends.
    initial begin
        #900000;
        $display("FAIL timeout: simulation still running at %0t", $time);
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [53:0] dut_fields();
        return {Oori, Hori, Wori, Oext, Hext, Wext};
    endfunction

    function automatic logic [2:0] cmd_bits(input logic [1:0] c);
        case (c)
            CMD_W:   return 3'b100;
            CMD_I:   return 3'b010;
            default: return 3'b001;
        endcase
    endfunction

    function automatic cfg_t mk(input int o, k, h, w, to, th, tw, tiles, wgts, input bit err);
        cfg_t c;
        c.o = o; c.k = k; c.h = h; c.w = w; c.to = to; c.th = th; c.tw = tw;
        c.exp_tiles = tiles; c.exp_wgts = wgts; c.exp_err = err;
        return c;
    endfunction

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    // Reference: enumerate tiles in o/h/w order; a weight load opens every o-tile.
    task automatic build_model(input cfg_t c);
        int hout, wout, toh, tow;
        logic [53:0] f;
        hout = c.h - c.k + 1;
        wout = c.w - c.k + 1;
        toh  = c.th - c.k + 1;
        tow  = c.tw - c.k + 1;
        exp_q.delete();
        for (int o = 0; o < c.o; o += c.to) begin
            for (int h = 0; h < hout; h += toh) begin
                for (int w = 0; w < wout; w += tow) begin
                    f = {11'(o), 8'(h), 8'(w), 11'(imin(c.to, c.o - o)),
                         8'(imin(toh, hout - h) + c.k - 1), 8'(imin(tow, wout - w) + c.k - 1)};
                    if (h == 0 && w == 0) exp_q.push_back({CMD_W, f});
                    exp_q.push_back({CMD_I, f});
                    exp_q.push_back({CMD_S, f});
                end
            end
        end
    endtask

    task automatic drive_cfg(input cfg_t c);
        O = 11'(c.o); K = 5'(c.k); H = 11'(c.h); W = 11'(c.w);
        tile_o = 11'(c.to); tile_h = 8'(c.th); tile_w = 8'(c.tw);
    endtask

    task automatic drive_junk_cfg();
        O = 11'($urandom_range(0, 2047)); K = 5'($urandom_range(0, 31));
        H = 11'($urandom_range(0, 2047)); W = 11'($urandom_range(0, 2047));
        tile_o = 11'($urandom_range(0, 2047));
        tile_h = 8'($urandom_range(0, 255)); tile_w = 8'($urandom_range(0, 255));
    endtask

    // Called at a negedge with the DUT idle; returns at a negedge with it idle.
    task automatic run_rejected(input cfg_t c);
        drive_cfg(c);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("rej_pulse", {cfg_err, busy, load_weight, load_input, store_output}, 5'b10000);
        @(negedge clk);
        check("rej_after", {cfg_err, busy, load_weight, load_input, store_output, finished}, 6'b0);
    endtask

    // Drives one accepted layer, answering every command with ld_done after a
    // random delay (50 cycles for the first store when long_s is set).
    task automatic run_layer(input cfg_t c, input int maxd, input bit long_s);
        logic [55:0] e;
        int d, n_w, n_s;
        bit stable, first_s;
        n_w = 0; n_s = 0; first_s = 1'b1;
        build_model(c);
        drive_cfg(c);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("busy_start", {busy, cfg_err}, 2'b10);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("cmd", {load_weight, load_input, store_output}, cmd_bits(e[55:54]));
            check("fields", dut_fields(), e[53:0]);
            if (load_weight)  n_w++;
            if (store_output) n_s++;
            if (long_s && first_s && e[55:54] == CMD_S) begin
                d = 50; first_s = 1'b0;
            end else begin
                d = $urandom_range(0, maxd);
            end
            stable = 1'b1;
            repeat (d) begin
                if ($urandom_range(0, 3) == 0) begin
                    start = 1'b1;
                    drive_junk_cfg();
                end
                @(negedge clk);
                start = 1'b0;
                if ({load_weight, load_input, store_output} != cmd_bits(e[55:54]) ||
                    dut_fields() != e[53:0] || !busy)
                    stable = 1'b0;
            end
            if (d > 0) check("hold", stable, 1'b1);
            ld_done = 1'b1;
            @(negedge clk);
            ld_done = 1'b0;
            if (e[55:54] == CMD_S) begin
                check("next_gap", {load_weight, load_input, store_output, busy, finished}, 5'b00010);
                @(negedge clk);
            end
        end
        check("finished", {finished, load_weight, load_input, store_output}, 4'b1000);
        @(negedge clk);
        check("idle_after", {finished, busy, load_weight, load_input, store_output, cfg_err}, 6'b0);
        if (c.exp_tiles >= 0) begin
            check("tile_count", 64'(n_s), 64'(c.exp_tiles));
            check("wgt_count", 64'(n_w), 64'(c.exp_wgts));
        end
    endtask

    initial begin
        cfg_t c;
        rst = 1'b1; start = 1'b0; ld_done = 1'b0;
        O = '0; K = '0; H = '0; W = '0; tile_o = '0; tile_h = '0; tile_w = '0;

        //             o     k  h    w    to    th   tw   tiles wgts err
        tbl[0]  = mk(2,    3, 10,  10,  2,    6,   6,   4,    1,   0);
        tbl[1]  = mk(2,    3, 10,  10,  2,    7,   7,   4,    1,   0);
        tbl[2]  = mk(5,    3, 10,  10,  2,    10,  10,  3,    3,   0);
        tbl[3]  = mk(1,    1, 1,   1,   1,    1,   1,   1,    1,   0);
        tbl[4]  = mk(1,    3, 258, 258, 4,    255, 255, 4,    1,   0);
        tbl[5]  = mk(2047, 5, 5,   5,   1024, 5,   5,   2,    2,   0);
        tbl[6]  = mk(2,    3, 10,  10,  2,    2,   6,   0,    0,   1);
        tbl[7]  = mk(2,    0, 10,  10,  2,    6,   6,   0,    0,   1);
        tbl[8]  = mk(0,    3, 10,  10,  2,    6,   6,   0,    0,   1);
        tbl[9]  = mk(2,    3, 10,  10,  0,    6,   6,   0,    0,   1);
        tbl[10] = mk(2,    3, 2,   10,  2,    6,   6,   0,    0,   1);
        tbl[11] = mk(2,    3, 10,  259, 2,    6,   6,   0,    0,   1);
        tbl[12] = mk(2,    3, 10,  10,  2,    6,   2,   0,    0,   1);

        // Reset values.
        repeat (3) @(negedge clk);
        check("reset_ctrl", {load_weight, load_input, store_output, busy, finished, cfg_err}, 6'b0);
        check("reset_fields", dut_fields(), 54'b0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_ctrl", {load_weight, load_input, store_output, busy, finished, cfg_err}, 6'b0);

        // Table-driven layers.
        for (int i = 0; i < 13; i++) begin
            if (tbl[i].exp_err) run_rejected(tbl[i]);
            else                run_layer(tbl[i], 3, 1'b0);
        end

        // store_output held through a 50-cycle ld_done delay.
        run_layer(tbl[0], 2, 1'b1);

        // start during INP is ignored; rst mid-OUT clears everything next cycle.
        drive_cfg(tbl[0]);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        ld_done = 1'b1;
        @(negedge clk);
        ld_done = 1'b0;
        check("inp_cmd", {load_weight, load_input, store_output}, 3'b010);
        O = 11'd7; tile_h = 8'd9; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("inp_ignore_start", {load_input, dut_fields()},
              {1'b1, 11'd0, 8'd0, 8'd0, 11'd2, 8'd6, 8'd6});
        ld_done = 1'b1;
        @(negedge clk);
        ld_done = 1'b0;
        check("out_cmd", {load_weight, load_input, store_output, dut_fields()},
              {3'b001, 11'd0, 8'd0, 8'd0, 11'd2, 8'd6, 8'd6});
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_ctrl", {load_weight, load_input, store_output, busy, finished, cfg_err}, 6'b0);
        check("rst_mid_fields", dut_fields(), 54'b0);
        rst = 1'b0;
        @(negedge clk);
        check("rst_mid_idle", {load_weight, load_input, store_output, busy}, 4'b0);
        run_layer(tbl[2], 2, 1'b0);

        // Random layers against the reference enumeration.
        for (int n = 0; n < 16; n++) begin
            c.k  = $urandom_range(1, 4);
            c.h  = c.k + $urandom_range(0, 16);
            c.w  = c.k + $urandom_range(0, 16);
            c.th = c.k + $urandom_range(1, 8);
            c.tw = c.k + $urandom_range(1, 8);
            c.o  = $urandom_range(1, 8);
            c.to = $urandom_range(1, 4);
            c.exp_tiles = -1; c.exp_wgts = -1; c.exp_err = 1'b0;
            run_layer(c, 3, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
